mdio_master: RTL and testbench
==============================

MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10: CLK cycles per MDC half-period; legal range 2..255.
REQ-002 SHALL have parameter PRE_LEN, default 32: preamble length in MDC bit periods; legal range 32..63.
REQ-003 SHALL have port CLK, input, 1: system clock; the block uses no other clock.
REQ-004 SHALL have port RST, input, 1: reset, synchronous to CLK and active-high.
REQ-005 SHALL have port CMD_VALID, input, 1: command request.
REQ-006 SHALL have port CMD_READY, output, 1: command accepted when CMD_VALID and CMD_READY are both high at a CLK rising edge.
REQ-007 SHALL have port CMD_WR, input, 1: 1 = write (OP 01), 0 = read (OP 10).
REQ-008 SHALL have ports CMD_PHYADR and CMD_REGADR, input, 5 each: PHY address and register address.
REQ-009 SHALL have port CMD_WDATA, input, 16: write data.
REQ-010 SHALL have port RSP_VALID, output, 1: one-CLK pulse at frame completion, for both reads and writes.
REQ-011 SHALL have port RSP_RDATA, output, 16: read data; held until the next read completes.
REQ-012 SHALL have port BUSY, output, 1: high from command accept until RSP_VALID.
REQ-013 SHALL have port MDC, output, 1: management clock.
REQ-014 SHALL have ports MDIO_I (input, 1), MDIO_O (output, 1) and MDIO_T (output, 1, active-low output enable; 1 = released), matching the MDIO slave core pinout.

Function
REQ-015 SHALL run MDC continuously from a divider counter; MDC toggles every CLK_DIV CLK cycles, giving MDC period 2*CLK_DIV.
REQ-016 SHALL update MDIO_O and MDIO_T only on the CLK cycle that produces an MDC falling edge ("fall event").
REQ-017 SHALL register MDIO_I into the shift register only on the CLK cycle that produces an MDC rising edge ("rise event").
REQ-018 SHALL use FSM states IDLE, PRE, ST, OP, PA, RA, TA, DATA, DONE.
REQ-019 IDLE: MDIO_T=1, MDIO_O=1, CMD_READY=1; on accept, latch all command fields, drop CMD_READY, and enter PRE at the next fall event.
REQ-020 PRE: drive 1 for PRE_LEN bit periods with MDIO_T=0.
REQ-021 ST: drive 0 then 1. OP: drive 01 for a write or 10 for a read. PA and RA: drive 5 bits each, MSB first.
REQ-022 TA for a write: drive 1 then 0 with MDIO_T=0.
REQ-023 TA for a read: MDIO_T=1 for both bit periods; MDIO_I is ignored during TA.
REQ-024 DATA for a write: drive CMD_WDATA for 16 bit periods, MSB first.
REQ-025 DATA for a read: MDIO_T=1; shift MDIO_I on the 16 rise events of the data bit periods, MSB first.
REQ-026 DONE: at the next fall event set MDIO_T=1 and MDIO_O=1, pulse RSP_VALID for one CLK, load RSP_RDATA (read only), and return to IDLE; CMD_READY rises the cycle after RSP_VALID.
REQ-027 Frame length SHALL be exactly PRE_LEN+32 bit periods from the first preamble fall event to the DONE fall event.
REQ-028 Bit counter SHALL be 6 bits wide; it reloads on every state change and never wraps within a state.
REQ-029 CMD_VALID while BUSY=1 SHALL be ignored (CMD_READY=0) and SHALL NOT alter the latched fields.
REQ-030 A read of an absent PHY SHALL return the sampled bus value; with the bus pulled up this is 0xFFFF, and no error flag is required.
REQ-031 Back-to-back commands SHALL be permitted; the preamble of the next frame starts at the first fall event after acceptance.

Reset
REQ-032 RST high SHALL, at the next CLK edge, set: MDC=0, divider=0, state=IDLE, MDIO_T=1, MDIO_O=1, CMD_READY=0, BUSY=0, RSP_VALID=0, RSP_RDATA=0x0000.
REQ-033 CMD_READY SHALL rise on the first CLK cycle after RST deasserts.
REQ-034 RST asserted mid-frame SHALL abort the frame with no RSP_VALID pulse; MDIO SHALL be released (MDIO_T=1) within one CLK.

Verification
REQ-035 Write P=1 R=3 D=0xA5C3, then read P=1 R=3, against gmii_mdio_slave PHYADR=1 -> read returns RSP_RDATA=0xA5C3 with one RSP_VALID per frame.
REQ-036 Read P=1 R=7 with no prior write -> RSP_RDATA=0x0007 (slave init value); MDIO_T=1 throughout TA and DATA; no bus contention (X) on MDIO.
REQ-037 Read P=2 against slave PHYADR=1 with pullup on MDIO -> RSP_RDATA=0xFFFF.
REQ-038 CLK_DIV=2: count MDC periods between accept and RSP_VALID -> 64 bit periods of frame; MDIO_O transitions only at MDC falling edges.
REQ-039 Assert RST during RA of a write -> no RSP_VALID, MDIO_T=1 in the next cycle; a subsequent write/read of R=4 D=0x1234 succeeds.
REQ-040 Hold CMD_VALID high with changing fields during a frame -> exactly one frame is issued, using the fields latched at accept.

Source files
------------

// File: rtl/mdio_master.sv
// mdio_master: clause-22 MDIO management master; one read or write frame per accepted command,
// MDC divided from CLK, MDIO launched on MDC falls and sampled on MDC rises.
module mdio_master #(
   parameter int CLK_DIV = 10,
   parameter int PRE_LEN = 32
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic        CMD_WR,
   input  logic [4:0]  CMD_PHYADR,
   input  logic [4:0]  CMD_REGADR,
   input  logic [15:0] CMD_WDATA,
   output logic        RSP_VALID,
   output logic [15:0] RSP_RDATA,
   output logic        BUSY,
   output logic        MDC,
   input  logic        MDIO_I,
   output logic        MDIO_O,
   output logic        MDIO_T
);
   typedef enum logic [3:0] {IDLE, PRE, ST, OP, PA, RA, TA, DATA, DONE} state_t;
   state_t state, nstate, succ;
   logic [7:0] div;
   logic [5:0] cnt, ncnt;
   logic tick, fall, rise, pend, wr, drv;
   logic [4:0] pa, ra;
   logic [15:0] wd, sh, fv;

   assign tick = div == 8'(CLK_DIV - 1);
   assign fall = tick && MDC;
   assign rise = tick && !MDC;
   assign CMD_READY = state == IDLE && !pend && !RSP_VALID && !RST;
   assign BUSY = pend || state != IDLE;
   assign succ = state_t'(state + 4'd1);

   // cnt holds the index of the field bit currently on the wire, counting down to 0
   always_comb begin
      nstate = state;
      ncnt = cnt;
      case (state)
         IDLE: if (fall && pend) begin
            nstate = PRE;
            ncnt = 6'(PRE_LEN - 1);
         end
         PRE, ST, OP, PA, RA, TA: if (fall) begin
            if (cnt == 6'd0) begin
               nstate = succ;
               ncnt = succ == PA || succ == RA ? 6'd4 : succ == DATA ? 6'd15 : 6'd1;
            end else ncnt = cnt - 6'd1;
         end
         DATA: if (fall && cnt != 6'd0) ncnt = cnt - 6'd1;
            else if (rise && cnt == 6'd0) begin
               nstate = DONE;
               ncnt = 6'd0;
            end
         DONE: if (fall) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // bit pattern of the field being entered, indexed by the next counter value
   assign fv = nstate == ST ? 16'h0001 : nstate == OP ? (wr ? 16'h0001 : 16'h0002) :
               nstate == PA ? {11'd0, pa} : nstate == RA ? {11'd0, ra} :
               nstate == TA ? 16'h0002 : nstate == DATA ? wd : 16'hFFFF;
   assign drv = nstate inside {PRE, ST, OP, PA, RA} || (wr && (nstate == TA || nstate == DATA));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= nstate;
         cnt <= ncnt;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         div <= '0;
         MDC <= 1'b0;
         MDIO_O <= 1'b1;
         MDIO_T <= 1'b1;
         RSP_VALID <= 1'b0;
         RSP_RDATA <= '0;
         pend <= 1'b0;
      end else begin
         div <= tick ? 8'd0 : div + 8'd1;
         MDC <= MDC ^ tick;
         RSP_VALID <= fall && state == DONE;
         if (CMD_VALID && CMD_READY) begin
            pend <= 1'b1;
            wr <= CMD_WR;
            pa <= CMD_PHYADR;
            ra <= CMD_REGADR;
            wd <= CMD_WDATA;
         end else if (state == IDLE && nstate == PRE) pend <= 1'b0;
         if (fall) begin
            MDIO_O <= !drv || fv[ncnt[3:0]];
            MDIO_T <= !drv;
         end
         if (rise && state == DATA && !wr) sh <= {sh[14:0], MDIO_I};
         if (fall && state == DONE && !wr) RSP_RDATA <= sh;
      end
   end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed + random MDIO frames checked against a bit-level frame model
// and a register-file PHY model answering reads on MDIO_I.
module tb_mdio_master;
   localparam int D = 2, P = 32, FL = P + 32;
   logic clk = 0, rst = 1;
   logic cmd_valid = 0, cmd_wr = 0, mdio_i = 1;
   logic [4:0] cmd_phyadr = 0, cmd_regadr = 0;
   logic [15:0] cmd_wdata = 0;
   logic cmd_ready, rsp_valid, busy, mdc, mdio_o, mdio_t;
   logic [15:0] rsp_rdata;
   int checks = 0, failures = 0, rsp_cnt = 0, viol = 0, n = 0;
   bit cap_on = 0;
   logic [FL-1:0] cap_o, cap_t;
   logic [15:0] regs [32];
   logic [15:0] exp_rdata = 0, cur_rd = 16'hFFFF;
   logic cur_wr = 1, pm = 0, rs;
   logic [1:0] prev_ot = 2'b11;

   always #5 clk = ~clk;

   mdio_master #(.CLK_DIV(D), .PRE_LEN(P)) dut (
      .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WR(cmd_wr),
      .CMD_PHYADR(cmd_phyadr), .CMD_REGADR(cmd_regadr), .CMD_WDATA(cmd_wdata),
      .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .BUSY(busy), .MDC(mdc),
      .MDIO_I(mdio_i), .MDIO_O(mdio_o), .MDIO_T(mdio_t)
   );

   always @(negedge clk) if (rsp_valid) rsp_cnt++;

   // record what the master puts on the wire at each MDC rise, starting at the first driven bit
   always @(posedge mdc) begin
      if (!cap_on && n == 0 && mdio_t === 1'b0) cap_on = 1;
      if (cap_on && n < FL) begin
         cap_o[FL-1-n] = mdio_o;
         cap_t[FL-1-n] = mdio_t;
         n++;
      end
   end

   // PHY model: presents read data during the data bits, otherwise the pull-up
   always @(negedge mdc)
      mdio_i = (cap_on && !cur_wr && n >= P + 16 && n < FL) ? cur_rd[FL-1-n] : 1'b1;

   // MDIO_O/MDIO_T may only move on a clock where MDC has just fallen
   always @(posedge clk) begin
      rs = rst;
      #1;
      if (!rs && {mdio_o, mdio_t} !== prev_ot && !(pm && !mdc)) viol++;
      pm = mdc;
      prev_ot = {mdio_o, mdio_t};
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wr, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
      int w = 0;
      @(negedge clk);
      cap_on = 0;
      n = 0;
      cap_o = 'x;
      cap_t = 'x;
      cur_wr = wr;
      cur_rd = (pa == 5'd1) ? regs[ra] : 16'hFFFF;
      cmd_valid = 1;
      cmd_wr = wr;
      cmd_phyadr = pa;
      cmd_regadr = ra;
      cmd_wdata = wd;
      while (!cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("accept", cmd_ready, 1);
      @(posedge clk);
   endtask

   task automatic do_cmd(input logic wr, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd, input bit noise);
      logic [FL-1:0] ef, et;
      int cyc = 0, c0;
      ef = {{P{1'b1}}, 2'b01, wr ? 2'b01 : 2'b10, pa, ra, wr ? 2'b10 : 2'b11, wr ? wd : 16'hFFFF};
      et = {{(P + 14){1'b0}}, wr ? 2'b00 : 2'b11, wr ? 16'h0000 : 16'hFFFF};
      issue(wr, pa, ra, wd);
      c0 = rsp_cnt;
      @(negedge clk);
      if (!noise) cmd_valid = 0;
      while (!rsp_valid && cyc < FL * 2 * D + 4 * D) begin
         if (noise) begin
            cmd_wr = 1'($urandom);
            cmd_phyadr = 5'($urandom);
            cmd_regadr = 5'($urandom);
            cmd_wdata = 16'($urandom);
         end
         if (cyc == 20) begin
            chk("busy_mid", busy, 1);
            chk("ready_mid", cmd_ready, 0);
         end
         @(negedge clk);
         cyc++;
      end
      cmd_valid = 0;
      if (!wr) exp_rdata = cur_rd;
      else if (pa == 5'd1) regs[ra] = wd;
      chk("frame_periods", (cyc - 1) / (2 * D), FL);
      chk("rdata", rsp_rdata, exp_rdata);
      chk("frame_oe", cap_t, et);
      chk("frame_bits", cap_o | et, ef | et);
      @(negedge clk);
      chk("rsp_once", rsp_cnt - c0, 1);
      chk("ready_after", cmd_ready, 1);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      int w = 0, c0;
      for (int i = 0; i < 32; i++) regs[i] = 16'(i);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mdc", mdc, 0);
      chk("rst_mdio_t", mdio_t, 1);
      chk("rst_mdio_o", mdio_o, 1);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      rst = 0;
      @(negedge clk);
      chk("ready_post_rst", cmd_ready, 1);
      do_cmd(1, 5'd1, 5'd3, 16'hA5C3, 0);
      do_cmd(0, 5'd1, 5'd3, 16'h0000, 0);
      do_cmd(0, 5'd1, 5'd7, 16'h0000, 0);
      do_cmd(0, 5'd2, 5'd5, 16'h0000, 0);
      do_cmd(1, 5'd1, 5'd9, 16'h3C5A, 1);
      do_cmd(0, 5'd1, 5'd9, 16'h0000, 1);
      issue(1, 5'd1, 5'd4, 16'hDEAD);
      @(negedge clk);
      cmd_valid = 0;
      c0 = rsp_cnt;
      while (n < P + 11 && w < FL * 4 * D) begin
         @(negedge clk);
         w++;
      end
      chk("abort_in_ra", n, P + 11);
      rst = 1;
      @(posedge clk);
      #1;
      chk("abort_release", mdio_t, 1);
      chk("abort_busy", busy, 0);
      @(negedge clk);
      rst = 0;
      repeat (FL * 2 * D) @(negedge clk);
      chk("abort_no_rsp", rsp_cnt - c0, 0);
      do_cmd(0, 5'd1, 5'd4, 16'h0000, 0);
      do_cmd(1, 5'd1, 5'd4, 16'h1234, 0);
      do_cmd(0, 5'd1, 5'd4, 16'h0000, 0);
      for (int i = 0; i < 4; i++)
         do_cmd(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 5'd2 : 5'd1,
                5'($urandom), 16'($urandom), 0);
      chk("mdio_edge_viol", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
